// File: rtl/riscv_core_mem_arbiter_if.sv
// Cache-side and memory-side signals of the refill arbiter.
// The slave modport is the arbiter's view; master is the view of the caches/memory around it.
interface riscv_core_mem_arbiter_if #(
  parameter int ADDR_WIDTH     = 64,
  parameter int AXI_DATA_WIDTH = 256
);
  logic                      i_ic_req;
  logic [ADDR_WIDTH-1:0]     i_ic_addr;
  logic                      o_ic_done;
  logic [AXI_DATA_WIDTH-1:0] o_ic_rdata;

  logic                      i_dc_req;
  logic                      i_dc_we;
  logic [ADDR_WIDTH-1:0]     i_dc_addr;
  logic [AXI_DATA_WIDTH-1:0] i_dc_wdata;
  logic                      o_dc_done;
  logic [AXI_DATA_WIDTH-1:0] o_dc_rdata;

  logic                      o_mem_req;
  logic                      o_mem_we;
  logic [ADDR_WIDTH-1:0]     o_mem_addr;
  logic [AXI_DATA_WIDTH-1:0] o_mem_wdata;
  logic                      i_mem_done;
  logic [AXI_DATA_WIDTH-1:0] i_mem_rdata;

  modport slave (
    input  i_ic_req, i_ic_addr, i_dc_req, i_dc_we, i_dc_addr, i_dc_wdata,
           i_mem_done, i_mem_rdata,
    output o_ic_done, o_ic_rdata, o_dc_done, o_dc_rdata,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_ic_req, i_ic_addr, i_dc_req, i_dc_we, i_dc_addr, i_dc_wdata,
           i_mem_done, i_mem_rdata,
    input  o_ic_done, o_ic_rdata, o_dc_done, o_dc_rdata,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/riscv_core_mem_arbiter.sv
// Shares the single memory port between icache and dcache refills, one transaction at a time.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests; otherwise DC has fixed priority.
module riscv_core_mem_arbiter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int AXI_DATA_WIDTH = 256
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  riscv_core_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_GAP} state_e;
  typedef enum logic {GR_IC = 1'b0, GR_DC = 1'b1} grant_e;

  state_e                    state_q;
  grant_e                    grant_q;
  logic                      mem_req_q;
  logic                      mem_we_q;
  logic [ADDR_WIDTH-1:0]     mem_addr_q;
  logic [AXI_DATA_WIDTH-1:0] mem_wdata_q;

  grant_e winner;
  logic   any_req;
  logic   done_ok;
  logic   ic_done;
  logic   dc_done;

`ifdef ARB_ROUND_ROBIN_EN
  grant_e last_q;
`endif

  assign any_req = bus.i_ic_req | bus.i_dc_req;

  // NOTE: give every always_comb output a value before any branch so no latch is inferred.
  always_comb begin
    winner = bus.i_dc_req ? GR_DC : GR_IC;
`ifdef ARB_ROUND_ROBIN_EN
    if (bus.i_ic_req && bus.i_dc_req) winner = (last_q == GR_DC) ? GR_IC : GR_DC;
`endif
  end

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: datapath registers are visible outputs, so they are reset too rather than left X.
      state_q     <= ST_IDLE;
      grant_q     <= GR_IC;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= GR_DC;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            state_q   <= ST_BUSY;
            grant_q   <= winner;
            mem_req_q <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= winner;
`endif
            if (winner == GR_DC) begin
              mem_we_q    <= bus.i_dc_we;
              mem_addr_q  <= bus.i_dc_addr;
              mem_wdata_q <= bus.i_dc_wdata;
            end else begin
              mem_we_q    <= 1'b0;
              mem_addr_q  <= bus.i_ic_addr;
              mem_wdata_q <= '0;
            end
          end
        end
        ST_BUSY: begin
          if (bus.i_mem_done) begin
            state_q   <= ST_GAP;
            mem_req_q <= 1'b0;
          end
        end
        // One dead cycle lets the finishing cache drop its request before arbitration resumes.
        ST_GAP:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done_ok = bus.i_mem_done && (state_q == ST_BUSY);
  assign ic_done = done_ok && (grant_q == GR_IC);
  assign dc_done = done_ok && (grant_q == GR_DC);

  assign bus.o_ic_done   = ic_done;
  assign bus.o_dc_done   = dc_done;
  assign bus.o_ic_rdata  = ic_done ? bus.i_mem_rdata : '0;
  assign bus.o_dc_rdata  = dc_done ? bus.i_mem_rdata : '0;
  assign bus.o_mem_req   = mem_req_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;

endmodule

// File: doc/riscv_core_mem_arbiter.md
# riscv_core_mem_arbiter

Two-requester refill arbiter that shares the single AXI-side memory port between the instruction-cache controller and the data-cache controller of the RV64I core. It latches one request at a time, drives the downstream memory request/address/data, and routes the completion pulse and read block back to the granted cache only. A turnaround cycle after every completion keeps a stale request from being re-granted while the finishing cache updates its tags.

## Interface
Parameters:
- ADDR_WIDTH, 64, byte address width
- AXI_DATA_WIDTH, 256, block transfer width (one cache line)

Ports:
- i_clk  input  1  core clock
- i_rst_n  input  1  reset; one clock, asynchronous, active-low
- i_ic_req  input  1  icache refill request; held until o_ic_done
- i_ic_addr  input  ADDR_WIDTH  icache line address (low 5 bits zero); stable while i_ic_req
- o_ic_done  output  1  one-cycle completion pulse to icache
- o_ic_rdata  output  AXI_DATA_WIDTH  refill block to icache; valid only with o_ic_done
- i_dc_req  input  1  dcache request; held until o_dc_done
- i_dc_we  input  1  1 = writeback, 0 = refill
- i_dc_addr  input  ADDR_WIDTH  dcache line address
- i_dc_wdata  input  AXI_DATA_WIDTH  writeback block
- o_dc_done  output  1  one-cycle completion pulse to dcache
- o_dc_rdata  output  AXI_DATA_WIDTH  refill block to dcache; valid only with o_dc_done
- o_mem_req  output  1  downstream request, level, registered
- o_mem_we  output  1  downstream write enable, registered
- o_mem_addr  output  ADDR_WIDTH  downstream address, registered
- o_mem_wdata  output  AXI_DATA_WIDTH  downstream write block, registered
- i_mem_done  input  1  downstream completion pulse
- i_mem_rdata  input  AXI_DATA_WIDTH  downstream read block, valid with i_mem_done

## Operation
- States: IDLE, BUSY, GAP. Grant register: IC or DC.
- IDLE: if any request asserted, choose winner (see Configuration), latch addr/we/wdata (icache: we=0, wdata=0) into output registers, set grant, go BUSY. No request: stay.
- BUSY: o_mem_req=1, outputs held constant. On i_mem_done: granted side's done = 1 that cycle, rdata = i_mem_rdata; go GAP.
- GAP: o_mem_req=0, requests ignored for exactly one cycle; go IDLE.
- o_ic_done/o_dc_done combinational: i_mem_done AND state==BUSY AND matching grant. Never both high. o_xx_rdata = i_mem_rdata when that done high, else 0.
- i_mem_done in IDLE or GAP: ignored, no pulse.
- Request withdrawn while BUSY: transaction still completes; done pulse still issued.
- Reset (any time, including mid-BUSY): state IDLE, o_mem_req/o_mem_we 0, o_mem_addr/o_mem_wdata 0, grant IC, round-robin pointer "last = DC"; in-flight transaction abandoned.

## Timing
- Request sampled in IDLE at edge N -> o_mem_req high from cycle N+1.
- Done same cycle as i_mem_done (zero latency); o_mem_req low from next cycle.
- Back-to-back: done at cycle D, GAP at D+1, next grant sampled at D+2, o_mem_req high D+3. Minimum 2 idle o_mem_req cycles between transactions.
- Requesters must drop req within one cycle after done (icache does: state 10 has no request).

## Configuration
- ARB_ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, grant goes to the side not granted last; pointer updates on each grant. Single request always wins.
- Undefined: fixed priority, DC wins over IC on simultaneous requests; pointer logic absent.

## Test plan
- Reset, then i_ic_req=1, addr=0x0000_0000_0000_1020 -> o_mem_req=1, o_mem_addr=0x...1020, o_mem_we=0 next cycle; i_mem_done with rdata=0xA5..A5 -> o_ic_done=1, o_ic_rdata=0xA5..A5, o_dc_done=0.
- i_dc_req=1, we=1, addr=0x2040, wdata=0x1234.. -> o_mem_we=1, o_mem_wdata=0x1234..; done -> o_dc_done only.
- Both request same cycle, macro undefined -> DC granted first, IC granted at D+2 after DC done; macro defined, last grant DC -> IC first, then DC.
- i_mem_done pulsed in IDLE and in GAP -> no done output, state unchanged.
- i_rst_n low mid-BUSY -> o_mem_req=0 immediately, all outputs 0; after release, pending IC request re-granted from IDLE with latency 1.
